// File: rtl/wb_timeout_bridge_if.sv
// Classic Wishbone signal bundle. The bridge uses one instance on its upstream
// side (slave view) and one on its downstream side (master view).
interface wb_timeout_bridge_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic        ack;
   logic [31:0] dat_r;

   modport master (output cyc, stb, we, sel, adr, dat_w, input ack, dat_r);
   modport slave  (input cyc, stb, we, sel, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/wb_timeout_bridge.sv
// Registered Wishbone pass-through that self-acks with error data when the
// downstream harness never answers, and counts those timeouts for debug.
module wb_timeout_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF,
   parameter int unsigned CNT_W          = 16
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rstn_i,
   wb_timeout_bridge_if.slave         wbs,
   wb_timeout_bridge_if.master        wbm,
   output logic [CNT_W-1:0]           timeout_cnt_o,
   output logic                       timeout_pulse_o,
   output logic                       busy_o
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_e             state_q, state_d;
   logic [15:0]        wait_q, wait_d;
   logic               stb_q, stb_d;
   logic               we_q, we_d;
   logic [3:0]         sel_q, sel_d;
   logic [31:0]        adr_q, adr_d;
   logic [31:0]        dat_q, dat_d;
   logic               ack_q, ack_d;
   logic [31:0]        rdat_q, rdat_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pulse_q, pulse_d;
   logic               busy_q, busy_d;

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d = state_q;
      wait_d  = wait_q;
      stb_d   = stb_q;
      we_d    = we_q;
      sel_d   = sel_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      ack_d   = 1'b0;
      rdat_d  = 32'h0;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (wbs.cyc && wbs.stb && !ack_q) begin
               we_d    = wbs.we;
               sel_d   = wbs.sel;
               adr_d   = wbs.adr;
               dat_d   = wbs.dat_w;
               stb_d   = 1'b1;
               wait_d  = 16'h0;
               state_d = REQ;
            end
         end
         REQ: begin
            if (!wbs.cyc) begin
               stb_d   = 1'b0;
               state_d = IDLE;
            end else if (wbm.ack) begin
               // A write never returns data, even if the harness drives some.
               rdat_d  = we_q ? 32'h0 : wbm.dat_r;
               ack_d   = 1'b1;
               stb_d   = 1'b0;
               state_d = RESP;
            end else if (wait_q == WAIT_LAST) begin
               rdat_d  = we_q ? 32'h0 : ERR_DATA;
               ack_d   = 1'b1;
               stb_d   = 1'b0;
               cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
               pulse_d = 1'b1;
               state_d = RESP;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         state_q <= IDLE;
         wait_q  <= 16'h0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= 4'h0;
         adr_q   <= 32'h0;
         dat_q   <= 32'h0;
         ack_q   <= 1'b0;
         rdat_q  <= 32'h0;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         ack_q   <= ack_d;
         rdat_q  <= rdat_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         busy_q  <= busy_d;
      end
   end

   assign wbm.cyc         = stb_q;
   assign wbm.stb         = stb_q;
   assign wbm.we          = we_q;
   assign wbm.sel         = sel_q;
   assign wbm.adr         = adr_q;
   assign wbm.dat_w       = dat_q;
   assign wbs.ack         = ack_q;
   assign wbs.dat_r       = rdat_q;
   assign timeout_cnt_o   = cnt_q;
   assign timeout_pulse_o = pulse_q;
   assign busy_o          = busy_q;

endmodule
